// File: rtl/blackjack_pkg.sv
// blackjack_pkg: event byte encodings emitted by the blackjack core and the
// serial transmitter state type. Optional macro BLACKJACK_UART_PARITY_EN adds
// an even-parity bit state (8E1 framing).
package blackjack_pkg;

    // Card events carry the rank (1-13) in the low nibble.
    localparam logic [7:0] EV_CARD_PLAYER  = 8'h10;
    localparam logic [7:0] EV_CARD_DEALER  = 8'h20;
    localparam logic [7:0] EV_TOTAL_PLAYER = 8'h30;
    localparam logic [7:0] EV_TOTAL_DEALER = 8'h31;
    localparam logic [7:0] EV_WIN          = 8'h40;
    localparam logic [7:0] EV_LOSE         = 8'h41;
    localparam logic [7:0] EV_PUSH         = 8'h42;
    localparam logic [7:0] EV_BLACKJACK    = 8'h43;

    // Build a card event byte from the receiving side and the card rank.
    function automatic logic [7:0] ev_card(input logic dealer, input logic [3:0] rank);
        return (dealer ? EV_CARD_DEALER : EV_CARD_PLAYER) | {4'h0, rank};
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef BLACKJACK_UART_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/blackjack_tx_fifo.sv
// blackjack_tx_fifo: small circular byte buffer between the core's event
// interface and the serializer. Pointers carry one extra wrap bit so full and
// empty are distinguishable; full is registered so it can drive ready directly.
module blackjack_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("blackjack_tx_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [AW:0]                 wptr_q, wptr_d, rptr_q, rptr_d;
    logic                        full_q, full_d;
    logic [DEPTH-1:0][WIDTH-1:0] mem_q;

    // Next pointers; push and pop on the same edge both take effect.
    always_comb begin
        wptr_d = wptr_q + (AW+1)'(push_i);
        rptr_d = rptr_q + (AW+1)'(pop_i);
        full_d = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    end

    // Pointer and full-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            full_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            full_q <= full_d;
        end
    end

    // Storage needs no reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

    assign head_o  = mem_q[rptr_q[AW-1:0]];
    assign full_o  = full_q;
    assign empty_o = (wptr_q == rptr_q);

endmodule

// File: rtl/blackjack_uart_tx.sv
// blackjack_uart_tx: buffers blackjack event bytes and serializes them as
// UART 8N1 (8E1 when BLACKJACK_UART_PARITY_EN is defined), LSB first, with
// back-to-back frames whenever the buffer still holds data at a stop bit end.
module blackjack_uart_tx
    import blackjack_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ev_valid,
    input  logic [7:0] ev_data,
    output logic       ev_ready,
    output logic       tx,
    output logic       busy
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("blackjack_uart_tx: CLK_HZ/BAUD must be >= 2");
    end

    tx_state_e       state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            push, pop, empty, full, wrap;
    logic [7:0]      head;

    assign push = ev_valid && !full;
    assign wrap = (baud_q == BAUD_MAX);

    blackjack_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (ev_data),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef BLACKJACK_UART_PARITY_EN
    logic par_q;

    // Even parity of the byte being sent, captured when it leaves the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   par_q <= 1'b0;
        else if (pop) par_q <= ^head;
    end
`endif

    // Frame sequencing; tx_d is the line level for the state being entered.
    always_comb begin
        state_d = state_q;
        baud_d  = wrap ? '0 : baud_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: if (wrap) begin
                state_d = ST_DATA;
                tx_d    = shift_q[0];
            end
            ST_DATA: if (wrap) begin
                if (bit_q == 3'd7) begin
`ifdef BLACKJACK_UART_PARITY_EN
                    state_d = ST_PARITY;
                    tx_d    = par_q;
`else
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    tx_d    = shift_q[1];
                end
            end
`ifdef BLACKJACK_UART_PARITY_EN
            ST_PARITY: if (wrap) begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
            end
`endif
            ST_STOP: if (wrap) begin
                bit_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State, counters, shifter and the registered line driver.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign ev_ready = !full;
    // Drops during the final stop-bit cycle when nothing else is queued.
    assign busy     = !empty || ((state_q != ST_IDLE) && !((state_q == ST_STOP) && wrap));

endmodule

// File: tb/tb_blackjack_uart_tx.sv
// Directed bench for blackjack_uart_tx at CLKS_PER_BIT=8: single frame,
// back-to-back frames, FIFO full back-pressure, push/pop at stop-bit end,
// and reset during a frame.
module tb_blackjack_uart_tx;
`ifdef BLACKJACK_UART_PARITY_EN
    localparam int FL = 88;
`else
    localparam int FL = 80;
`endif

    logic       clk, rst_n, ev_valid, ev_ready, tx, busy;
    logic [7:0] ev_data;
    int         total = 0;
    int         bad   = 0;
    logic [7:0] q[$];
    bit         pend;

    blackjack_uart_tx #(.CLK_HZ(8), .BAUD(1), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ev_valid (ev_valid),
        .ev_data  (ev_data),
        .ev_ready (ev_ready),
        .tx       (tx),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte feeder: presents the queue head at each negedge, retires it once
    // it was presented with ready high through a rising edge.
    initial begin
        ev_valid = 1'b0;
        ev_data  = 8'h00;
        pend     = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) void'(q.pop_front());
            if (q.size() > 0) begin
                ev_valid = 1'b1;
                ev_data  = q[0];
                pend     = ev_ready;
            end else begin
                ev_valid = 1'b0;
                pend     = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of the first start-bit cycle; checks every cycle
    // of the frame and leaves at the negedge just after it. Ready is expected
    // low for frame-relative cycles rlo..rhi.
    task automatic check_frame(input string tag, input logic [7:0] b, input logic par,
                               input logic last, input int rlo, input int rhi);
        logic [10:0] bits;
        bits = {1'b1, par, b, 1'b0};
`ifndef BLACKJACK_UART_PARITY_EN
        bits[9] = 1'b1;
`endif
        for (int k = 0; k < FL; k++) begin
            chk({tag, "_tx"},   32'(tx),       32'(bits[k/8]));
            chk({tag, "_busy"}, 32'(busy),     (last && k == FL-1) ? 0 : 1);
            chk({tag, "_rdy"},  32'(ev_ready), (k >= rlo && k <= rhi) ? 0 : 1);
            @(negedge clk);
        end
    endtask

    initial begin
        int lows;
        int busys;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx",   32'(tx),       1);
        chk("rst_rdy",  32'(ev_ready), 1);
        chk("rst_busy", 32'(busy),     0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_tx",   32'(tx),   1);
        chk("idle_busy", 32'(busy), 0);

        // Single byte A5: accepted at edge N, start bit from cycle N+1.
        @(posedge clk); #1;
        q.push_back(8'hA5);
        @(negedge clk);
        @(negedge clk);
        chk("a5_busy_rise", 32'(busy), 1);
        chk("a5_pre_tx",    32'(tx),   1);
        @(negedge clk);
        check_frame("a5", 8'hA5, 1'b0, 1'b1, 1, 0);
        chk("a5_end_tx",   32'(tx),   1);
        chk("a5_end_busy", 32'(busy), 0);

        // Back-to-back: second start immediately after first stop.
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        q.push_back(8'h10);
        q.push_back(8'h43);
        @(negedge clk);
        @(negedge clk);
        chk("bb_busy_rise", 32'(busy), 1);
        @(negedge clk);
        check_frame("b10", 8'h10, 1'b1, 1'b0, 1, 0);
        check_frame("b43", 8'h43, 1'b1, 1'b1, 1, 0);
        chk("bb_end_busy", 32'(busy), 0);

        // FIFO full: 1 pops at once, 2..5 fill, 6 waits for the next pop.
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        for (int i = 1; i <= 6; i++) q.push_back(8'(i));
        @(negedge clk);
        @(negedge clk);
        chk("ff_rdy_n", 32'(ev_ready), 1);
        @(negedge clk);
        check_frame("f1", 8'h01, 1'b1, 1'b0, 3, FL-1);
        check_frame("f2", 8'h02, 1'b1, 1'b0, 1, FL-1);
        check_frame("f3", 8'h03, 1'b0, 1'b0, 1, 0);
        check_frame("f4", 8'h04, 1'b1, 1'b0, 1, 0);
        check_frame("f5", 8'h05, 1'b0, 1'b0, 1, 0);
        check_frame("f6", 8'h06, 1'b0, 1'b1, 1, 0);
        chk("ff_qempty", 32'(q.size()), 0);

        // Push landing on the edge that ends a stop bit while one entry waits.
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        q.push_back(8'h40);
        q.push_back(8'h41);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        fork
            check_frame("s40", 8'h40, 1'b1, 1'b0, 1, 0);
            begin
                repeat (FL-1) @(posedge clk);
                #1 q.push_back(8'h42);
            end
        join
        check_frame("s41", 8'h41, 1'b0, 1'b0, 1, 0);
        check_frame("s42", 8'h42, 1'b0, 1'b1, 1, 0);

        // Parity-sensitive bytes: 07 has odd weight, 03 even.
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        q.push_back(8'h07);
        q.push_back(8'h03);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_frame("p07", 8'h07, 1'b1, 1'b0, 1, 0);
        check_frame("p03", 8'h03, 1'b0, 1'b1, 1, 0);

        // Reset during data bit 3 of FF with 00 still queued.
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        q.push_back(8'hFF);
        q.push_back(8'h00);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        repeat (35) @(negedge clk);
        chk("rm_bit3_tx",   32'(tx),   1);
        chk("rm_bit3_busy", 32'(busy), 1);
        #1 chk("rm_pre_tx", 32'(tx), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rm_tx",   32'(tx),       1);
        chk("rm_busy", 32'(busy),     0);
        chk("rm_rdy",  32'(ev_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lows  = 0;
        busys = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (tx !== 1'b1)   lows++;
            if (busy !== 1'b0) busys++;
        end
        chk("rm_no_frame_tx",   32'(lows),  0);
        chk("rm_no_frame_busy", 32'(busys), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
